// File: rtl/blast_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blast_pkg
// Brief    : Shared types and constants for the BLAST seed-hit finder:
//            nucleotide encoding and the scan state machine encoding.
// Revision : 1.0 - initial release
// ============================================================================
package blast_pkg;

    // Bits per nucleotide in every packed sequence.
    localparam int NT_W = 2;

    // Nucleotide codes.
    localparam logic [NT_W-1:0] NT_A = 2'd0;
    localparam logic [NT_W-1:0] NT_C = 2'd1;
    localparam logic [NT_W-1:0] NT_G = 2'd2;
    localparam logic [NT_W-1:0] NT_T = 2'd3;

    // Scan sequencer states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } state_t;

    // The hit record {qpos, dpos} depends on the top-level widths, so it is
    // declared inside blast_seed_hit_finder from that module's parameters.

endpackage
`default_nettype wire

// File: rtl/hit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hit_fifo
// Brief    : Count-based first-word-fall-through FIFO. The head entry is
//            always visible on o_headData while o_empty is low.
// Revision : 1.0 - initial release
// ============================================================================
module hit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_headData,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    // Push is judged on the count before any same-cycle pop.
    assign o_full     = (r_count == c_FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign w_doPush   = i_push & ~o_full;
    assign w_doPop    = i_pop & ~o_empty;
    assign o_headData = r_mem[r_rdPtr];

    // Storage array; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/blast_seed_hit_finder.sv
`default_nettype none
// ============================================================================
// Module   : blast_seed_hit_finder
// Brief    : Slides every WORD_NT-mer of a database window against every
//            query offset and streams each (qpos, dpos) seed hit, lowest
//            query offset first, through a backpressured FWFT hit FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module blast_seed_hit_finder
    import blast_pkg::*;
#(
    parameter int QUERY_NT   = 256,
    parameter int DB_NT      = 256,
    parameter int WORD_NT    = 11,
    parameter int LOC_W      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int QPOS_W     = $clog2(QUERY_NT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*QUERY_NT-1:0]  query_in,
    input  logic                   query_valid,
    input  logic [2*DB_NT-1:0]     db_in,
    input  logic [LOC_W-1:0]       db_base,
    input  logic                   db_valid,
    output logic                   db_ready,
    input  logic                   abort,
    output logic                   hit_valid,
    input  logic                   hit_ready,
    output logic [QPOS_W-1:0]      hit_qpos,
    output logic [LOC_W-1:0]       hit_dpos,
    output logic                   busy,
    output logic                   done
);

    localparam int c_NOFF     = QUERY_NT - WORD_NT + 1;
    localparam int c_LAST_POS = DB_NT - WORD_NT;
    localparam int c_POS_W    = $clog2(DB_NT);
    localparam int c_HIT_W    = QPOS_W + LOC_W;
    localparam logic [c_POS_W-1:0] c_LAST = c_POS_W'(c_LAST_POS);

    typedef struct packed {
        logic [QPOS_W-1:0] qpos;
        logic [LOC_W-1:0]  dpos;
    } hit_t;

    state_t                   r_state;
    logic [2*QUERY_NT-1:0]    r_query;
    logic [2*DB_NT-1:0]       r_db;
    logic [LOC_W-1:0]         r_base;
    logic [c_POS_W-1:0]       r_pos;
    logic [c_NOFF-1:0]        r_match;
    logic                     r_done;

    logic [2*WORD_NT-1:0]     w_dbWord;
    logic [c_NOFF-1:0]        w_cmp;
    logic                     w_fifoFull;
    logic                     w_fifoEmpty;
    logic                     w_push;
    hit_t                     w_pushHit;
    hit_t                     w_head;

    // Index of the lowest set bit; vector assumed nonzero when used.
    function automatic logic [QPOS_W-1:0] lowestSet(input logic [c_NOFF-1:0] vec);
        logic [QPOS_W-1:0] idx;
        idx = '0;
        for (int i = c_NOFF - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = QPOS_W'(i);
            end
        end
        return idx;
    endfunction

    // The current database word always sits in the low bits of the shifter.
    assign w_dbWord = r_db[2*WORD_NT-1:0];

    generate
        for (genvar gi = 0; gi < c_NOFF; gi++) begin : g_cmp
            assign w_cmp[gi] = (r_query[NT_W*gi +: 2*WORD_NT] == w_dbWord);
        end
    endgenerate

    // abort wins over a same-cycle push so nothing from a killed window leaks.
    assign w_push         = (r_state == SCAN) && (|r_match) && !w_fifoFull && !abort;
    assign w_pushHit.qpos = lowestSet(r_match);
    assign w_pushHit.dpos = r_base + LOC_W'(r_pos);

    // Sequencer: load, compare one position, enumerate its hits, advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pos   <= '0;
            r_match <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != IDLE)) begin
                r_state <= IDLE;
                r_match <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (query_valid) begin
                            r_query <= query_in;
                        end
                        if (db_valid) begin
                            r_db    <= db_in;
                            r_base  <= db_base;
                            r_pos   <= '0;
                            r_state <= COMPARE;
                        end
                    end
                    COMPARE: begin
                        r_match <= w_cmp;
                        r_state <= SCAN;
                    end
                    SCAN: begin
                        if (r_match == '0) begin
                            if (r_pos == c_LAST) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_db    <= r_db >> NT_W;
                                r_pos   <= r_pos + c_POS_W'(1);
                                r_state <= COMPARE;
                            end
                        end else if (!w_fifoFull) begin
                            // Clear the lowest set bit, the one just pushed.
                            r_match <= r_match & (r_match - c_NOFF'(1));
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    hit_fifo #(
        .WIDTH (c_HIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_hitFifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pushData (w_pushHit),
        .i_pop      (hit_valid & hit_ready),
        .o_headData (w_head),
        .o_full     (w_fifoFull),
        .o_empty    (w_fifoEmpty)
    );

    assign hit_valid = ~w_fifoEmpty;
    assign hit_qpos  = w_head.qpos;
    assign hit_dpos  = w_head.dpos;
    assign busy      = (r_state != IDLE);
    assign db_ready  = (r_state == IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_blast_seed_hit_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_blast_seed_hit_finder
// Brief    : Directed self-checking bench for blast_seed_hit_finder with
//            QUERY_NT=16, DB_NT=8, WORD_NT=4, FIFO_DEPTH=4, LOC_W=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blast_seed_hit_finder;

    localparam int QN = 16;
    localparam int DN = 8;
    localparam int WN = 4;
    localparam int LW = 32;
    localparam int FD = 4;
    localparam int QW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2*QN-1:0] query_in = '0;
    logic            query_valid = 1'b0;
    logic [2*DN-1:0] db_in = '0;
    logic [LW-1:0]   db_base = '0;
    logic            db_valid = 1'b0;
    logic            db_ready;
    logic            abort = 1'b0;
    logic            hit_valid;
    logic            hit_ready = 1'b0;
    logic [QW-1:0]   hit_qpos;
    logic [LW-1:0]   hit_dpos;
    logic            busy;
    logic            done;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [QW+LW-1:0] hits[$];
    int               doneCnt;

    always #5 clk = ~clk;

    blast_seed_hit_finder #(
        .QUERY_NT   (QN),
        .DB_NT      (DN),
        .WORD_NT    (WN),
        .LOC_W      (LW),
        .FIFO_DEPTH (FD),
        .QPOS_W     (QW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .query_in    (query_in),
        .query_valid (query_valid),
        .db_in       (db_in),
        .db_base     (db_base),
        .db_valid    (db_valid),
        .db_ready    (db_ready),
        .abort       (abort),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .hit_qpos    (hit_qpos),
        .hit_dpos    (hit_dpos),
        .busy        (busy),
        .done        (done)
    );

    // Pack a nucleotide string; character j becomes nucleotide j.
    function automatic logic [31:0] packNt(input string s);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < s.len(); j++) begin
            case (s[j])
                "A":     v[2*j +: 2] = 2'd0;
                "C":     v[2*j +: 2] = 2'd1;
                "G":     v[2*j +: 2] = 2'd2;
                default: v[2*j +: 2] = 2'd3;
            endcase
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer a window (optionally with a new query); returns at the negedge
    // right after the accepting edge.
    task automatic offer(input string q, input string d, input logic [LW-1:0] base,
                         input bit loadQ);
        logic [31:0] dv;
        dv          = packNt(d);
        query_in    = packNt(q);
        query_valid = loadQ;
        db_in       = dv[2*DN-1:0];
        db_base     = base;
        db_valid    = 1'b1;
        tick();
        query_valid = 1'b0;
        db_valid    = 1'b0;
    endtask

    // Collect popped hits and done pulses until idle with an empty FIFO.
    task automatic drain(input int maxCyc, output bit timedOut);
        timedOut = 1'b1;
        for (int k = 0; k < maxCyc; k++) begin
            if (hit_valid && hit_ready) hits.push_back({hit_qpos, hit_dpos});
            if (done) doneCnt++;
            if (!busy && !hit_valid) begin
                timedOut = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        nCompared++;
        if (hit_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_hit_valid: got %b expected 0", hit_valid); end
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nCompared++;
        if (done !== 1'b0) begin nMismatched++; $display("FAIL reset_done: got %b expected 0", done); end
        nCompared++;
        if (db_ready !== 1'b1) begin nMismatched++; $display("FAIL reset_db_ready: got %b expected 1", db_ready); end
    endtask

    task automatic test_single_hit();
        bit to;
        hits.delete();
        doneCnt   = 0;
        hit_ready = 1'b1;
        offer("TTTTTACGTTTTTTTT", "ACGTGGGG", 32'd100, 1'b1);
        drain(200, to);
        nCompared++;
        if (to) begin nMismatched++; $display("FAIL single_timeout: window did not finish"); end
        nCompared++;
        if (hits.size() != 1) begin
            nMismatched++; $display("FAIL single_count: got %0d hits expected 1", hits.size());
        end else begin
            nCompared++;
            if (hits[0] !== {4'd5, 32'd100}) begin
                nMismatched++; $display("FAIL single_hit: got %h expected %h", hits[0], {4'd5, 32'd100});
            end
        end
        nCompared++;
        if (doneCnt != 1) begin nMismatched++; $display("FAIL single_done: got %0d pulses expected 1", doneCnt); end
    endtask

    task automatic test_backpressure();
        bit to;
        int early;
        hits.delete();
        doneCnt   = 0;
        early     = 0;
        hit_ready = 1'b0;
        offer("AAAAAAAAAAAAAAAA", "AAAAAAAA", 32'd200, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (done) early++;
            tick();
        end
        nCompared++;
        if (hit_valid !== 1'b1 || busy !== 1'b1 || early != 0) begin
            nMismatched++;
            $display("FAIL bp_stall: got valid=%b busy=%b done=%0d expected valid=1 busy=1 done=0", hit_valid, busy, early);
        end
        nCompared++;
        if ({hit_qpos, hit_dpos} !== {4'd0, 32'd200}) begin
            nMismatched++; $display("FAIL bp_head: got %h expected %h", {hit_qpos, hit_dpos}, {4'd0, 32'd200});
        end
        hit_ready = 1'b1;
        drain(500, to);
        nCompared++;
        if (to || hits.size() != 65) begin
            nMismatched++; $display("FAIL bp_count: got %0d hits timeout=%b expected 65", hits.size(), to);
        end else begin
            for (int i = 0; i < 65; i++) begin
                logic [QW+LW-1:0] exp;
                exp = {QW'(i % 13), LW'(200 + i / 13)};
                nCompared++;
                if (hits[i] !== exp) begin
                    nMismatched++; $display("FAIL bp_order[%0d]: got %h expected %h", i, hits[i], exp);
                end
            end
        end
        nCompared++;
        if (doneCnt != 1) begin nMismatched++; $display("FAIL bp_done: got %0d pulses expected 1", doneCnt); end
    endtask

    task automatic test_no_match();
        int firstDone;
        int nHits;
        firstDone = -1;
        nHits     = 0;
        hit_ready = 1'b1;
        offer("AAAAAAAAAAAAAAAA", "TTTTTTTT", 32'd0, 1'b1);
        for (int k = 0; k < 30; k++) begin
            if (done && firstDone < 0) firstDone = k;
            if (hit_valid) nHits++;
            tick();
        end
        nCompared++;
        if (firstDone != 10) begin nMismatched++; $display("FAIL nomatch_done_cycle: got %0d expected 10", firstDone); end
        nCompared++;
        if (nHits != 0) begin nMismatched++; $display("FAIL nomatch_hits: got %0d expected 0", nHits); end
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("FAIL nomatch_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_wrap();
        bit to;
        hits.delete();
        doneCnt   = 0;
        hit_ready = 1'b1;
        offer("CCCCTTTTTTTTTTTT", "GCCCCCGG", 32'hFFFF_FFFE, 1'b1);
        drain(200, to);
        nCompared++;
        if (to || hits.size() != 2) begin
            nMismatched++; $display("FAIL wrap_count: got %0d hits timeout=%b expected 2", hits.size(), to);
        end else begin
            nCompared++;
            if (hits[0] !== {4'd0, 32'hFFFF_FFFF}) begin
                nMismatched++; $display("FAIL wrap_hit0: got %h expected %h", hits[0], {4'd0, 32'hFFFF_FFFF});
            end
            nCompared++;
            if (hits[1] !== {4'd0, 32'h0000_0000}) begin
                nMismatched++; $display("FAIL wrap_hit1: got %h expected %h", hits[1], {4'd0, 32'h0000_0000});
            end
        end
    endtask

    task automatic test_abort();
        bit to;
        bit fired;
        hits.delete();
        doneCnt   = 0;
        fired     = 1'b0;
        hit_ready = 1'b1;
        offer("AAAAAAAAAAAAAAAA", "AAAAAAAA", 32'd300, 1'b1);
        for (int k = 0; k < 200 && !fired; k++) begin
            if (done) doneCnt++;
            if (hit_valid) begin
                hits.push_back({hit_qpos, hit_dpos});
                if (hit_dpos == 32'd302) begin
                    abort = 1'b1;
                    fired = 1'b1;
                end
            end
            tick();
        end
        abort = 1'b0;
        nCompared++;
        if (!fired || busy !== 1'b0 || db_ready !== 1'b1 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL abort_idle: got fired=%b busy=%b db_ready=%b done=%b expected 1 0 1 0", fired, busy, db_ready, done);
        end
        drain(50, to);
        nCompared++;
        if (to || hits.size() != 27) begin
            nMismatched++; $display("FAIL abort_count: got %0d hits timeout=%b expected 27", hits.size(), to);
        end else begin
            nCompared++;
            if (hits[26] !== {4'd0, 32'd302}) begin
                nMismatched++; $display("FAIL abort_last: got %h expected %h", hits[26], {4'd0, 32'd302});
            end
        end
        nCompared++;
        if (doneCnt != 0) begin nMismatched++; $display("FAIL abort_no_done: got %0d pulses expected 0", doneCnt); end
        hits.delete();
        doneCnt = 0;
        offer("TTTTTACGTTTTTTTT", "ACGTGGGG", 32'd500, 1'b1);
        drain(200, to);
        nCompared++;
        if (to || hits.size() != 1 || doneCnt != 1) begin
            nMismatched++; $display("FAIL abort_next_window: got %0d hits %0d done expected 1 1", hits.size(), doneCnt);
        end else begin
            nCompared++;
            if (hits[0] !== {4'd5, 32'd500}) begin
                nMismatched++; $display("FAIL abort_next_hit: got %h expected %h", hits[0], {4'd5, 32'd500});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        hit_ready = 1'b0;
        offer("AAAAAAAAAAAAAAAA", "AAAAAAAA", 32'd600, 1'b1);
        tick();
        query_in    = packNt("TTTTTTTTTTTTTTTT");
        query_valid = 1'b1;
        tick();
        tick();
        query_valid = 1'b0;
        tick();
        nCompared++;
        if (hit_valid !== 1'b1 || busy !== 1'b1) begin
            nMismatched++; $display("FAIL rstmid_pre: got valid=%b busy=%b expected 1 1", hit_valid, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nCompared++;
        if (hit_valid !== 1'b0 || busy !== 1'b0 || db_ready !== 1'b1) begin
            nMismatched++;
            $display("FAIL rstmid_post: got valid=%b busy=%b db_ready=%b expected 0 0 1", hit_valid, busy, db_ready);
        end
        hits.delete();
        doneCnt   = 0;
        hit_ready = 1'b1;
        offer("TTTTTTTTTTTTTTTT", "AAAAAAAA", 32'd700, 1'b0);
        drain(500, to);
        nCompared++;
        if (to || hits.size() != 65 || doneCnt != 1) begin
            nMismatched++; $display("FAIL rstmid_old_query: got %0d hits %0d done expected 65 1", hits.size(), doneCnt);
        end else begin
            nCompared++;
            if (hits[64] !== {4'd12, 32'd704}) begin
                nMismatched++; $display("FAIL rstmid_last: got %h expected %h", hits[64], {4'd12, 32'd704});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_hit();
        test_backpressure();
        test_no_match();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
